// File: rtl/cpu_pkg.sv
// Shared CPU constants: sequencer state codes and opcode/function groups.
// Used by the sequencer and the control decoder.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_MD_WAIT = 3'd1,
    S_MEM     = 3'd2,
    S_EXEC    = 3'd3,
    S_HALT    = 3'd4
  } state_t;

  localparam logic [5:0] OP_SPECIAL = 6'd0;
  localparam logic [5:0] OP_LB      = 6'd32;
  localparam logic [5:0] OP_LWR     = 6'd38;
  localparam logic [5:0] OP_SB      = 6'd40;
  localparam logic [5:0] OP_SH      = 6'd41;
  localparam logic [5:0] OP_SW      = 6'd43;

  localparam logic [5:0] FN_MULT    = 6'd24;
  localparam logic [5:0] FN_DIVU    = 6'd27;

  function automatic logic is_ldst(input logic [5:0] op);
    return ((op >= OP_LB) && (op <= OP_LWR)) ||
           (op == OP_SB) || (op == OP_SH) ||
           (op == OP_SW);
  endfunction

  function automatic logic is_multdiv(
    input logic [5:0] op,
    input logic [5:0] fn
  );
    return (op == OP_SPECIAL) &&
           (fn >= FN_MULT) && (fn <= FN_DIVU);
  endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// Counts consecutive bus stall cycles; o_expired flags the last allowed one.
// Ports: clk, reset, i_stall (stall this cycle), o_expired (abort now).
module bus_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic i_stall,
  output logic o_expired
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);

  logic [W-1:0] r_cnt;

  // The cycle that brings the count to TIMEOUT_CYCLES aborts the access.
  assign o_expired = i_stall &&
                     (r_cnt == W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset || !i_stall)
      r_cnt <= '0;
    else if (!o_expired)
      r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multicycle CPU sequencer: FETCH/EXEC/MEM/MD_WAIT/HALT with halt-on-PC-0.
// Ports: clk, reset, waitrequest, opcode, function_code, md_busy,
//   next_pc_zero -> state, active, ir_load, pc_enable, md_start, bus_error.
// Optional macro BUS_TIMEOUT_EN adds a stall timeout that halts the CPU.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       waitrequest,
  input  logic [5:0] opcode,
  input  logic [5:0] function_code,
  input  logic       md_busy,
  input  logic       next_pc_zero,
  output logic [2:0] state,
  output logic       active,
  output logic       ir_load,
  output logic       pc_enable,
  output logic       md_start,
  output logic       bus_error
);

  state_t r_state;
  state_t w_next;
  logic   r_active;
  logic   w_stall;
  logic   w_expired;

  assign state  = r_state;
  assign active = r_active;

  assign w_stall = !reset && waitrequest &&
                   ((r_state == S_FETCH) ||
                    (r_state == S_MEM));

`ifdef BUS_TIMEOUT_EN
  logic r_bus_error;

  bus_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .i_stall  (w_stall),
    .o_expired(w_expired)
  );

  always_ff @(posedge clk) begin
    if (reset)
      r_bus_error <= 1'b0;
    else if (w_expired)
      r_bus_error <= 1'b1;
  end

  assign bus_error = r_bus_error;
`else
  logic w_unused;
  assign w_unused  = w_stall;
  assign w_expired = 1'b0;
  assign bus_error = 1'b0;
`endif

  always_comb begin
    w_next    = r_state;
    ir_load   = 1'b0;
    pc_enable = 1'b0;
    md_start  = 1'b0;
    if (!reset) begin
      unique case (r_state)
        S_FETCH: begin
          if (!waitrequest) begin
            ir_load = 1'b1;
            w_next  = S_EXEC;
          end
        end
        S_EXEC: begin
          if (is_ldst(opcode)) begin
            w_next = S_MEM;
          end else if (is_multdiv(opcode, function_code)) begin
            md_start = 1'b1;
            w_next   = S_MD_WAIT;
          end else begin
            pc_enable = 1'b1;
            w_next    = S_FETCH;
          end
        end
        S_MEM: begin
          if (!waitrequest) begin
            pc_enable = 1'b1;
            w_next    = S_FETCH;
          end
        end
        S_MD_WAIT: begin
          if (!md_busy) begin
            pc_enable = 1'b1;
            w_next    = S_FETCH;
          end
        end
        S_HALT: w_next = S_HALT;
        default: w_next = S_HALT;
      endcase
      // Committing PC 0 means the program jumped to the halt vector.
      if (pc_enable && next_pc_zero)
        w_next = S_HALT;
      if (w_expired)
        w_next = S_HALT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_FETCH;
      r_active <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_active <= (w_next != S_HALT);
    end
  end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: consecutive waitrequest-high cycles that abort a bus access (used only with BUS_TIMEOUT_EN).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 waitrequest  input  1  bus stall from the memory interface.
REQ-005 opcode  input  6  instruction[31:26] of the latched instruction.
REQ-006 function_code  input  6  instruction[5:0] of the latched instruction.
REQ-007 md_busy  input  1  multiply/divide unit busy.
REQ-008 next_pc_zero  input  1  high when the PC value about to be committed equals 0x00000000.
REQ-009 state  output  3  registered CPU state, consumed by the control decoder.
REQ-010 active  output  1  registered; high while the CPU is executing.
REQ-011 ir_load  output  1  combinational; latch the instruction register this cycle.
REQ-012 pc_enable  output  1  combinational; commit the next PC this cycle.
REQ-013 md_start  output  1  combinational; one-cycle start pulse to the multiply/divide unit.
REQ-014 bus_error  output  1  registered, sticky; bus access timed out.

Function
REQ-015 States SHALL be encoded as FETCH=0, MD_WAIT=1, MEM=2, EXEC=3, HALT=4; codes 5-7 SHALL go to HALT on the next edge.
REQ-016 FETCH: with waitrequest=1, remain in FETCH. With waitrequest=0, assert ir_load and go to EXEC next cycle.
REQ-017 EXEC, load/store opcode (32-38, 40, 41, 43): go to MEM; pc_enable=0.
REQ-018 EXEC, opcode 0 with function_code 24-27: assert md_start for that cycle and go to MD_WAIT.
REQ-019 EXEC, any other instruction: assert pc_enable and go to FETCH.
REQ-020 MEM: with waitrequest=1, remain. With waitrequest=0, assert pc_enable and go to FETCH.
REQ-021 MD_WAIT: the cycle after md_start, md_busy SHALL be sampled; while it is 1, remain. When it is 0, assert pc_enable and go to FETCH.
REQ-022 Halt detection: in any cycle where pc_enable=1 and next_pc_zero=1, the next state SHALL be HALT instead of FETCH; active SHALL go to 0 on that edge.
REQ-023 HALT is absorbing until reset: ir_load=pc_enable=md_start=0.
REQ-024 ir_load, pc_enable and md_start SHALL each be high for at most one cycle per instruction and never simultaneously.
REQ-025 Latency: a non-memory, non-multdiv instruction with zero wait states SHALL take exactly 2 cycles (FETCH, EXEC). A load/store with zero wait states SHALL take exactly 3 cycles.

Reset
REQ-026 While reset=1: state=FETCH, active=0, bus_error=0, timeout counter=0, and ir_load=pc_enable=md_start=0.
REQ-027 On the first cycle after reset deasserts: active=1 and state=FETCH.
REQ-028 Reset mid-operation (any state, including HALT) SHALL abandon the instruction without asserting pc_enable.

Configuration
REQ-029 With macro BUS_TIMEOUT_EN defined, a counter SHALL track consecutive waitrequest=1 cycles in FETCH or MEM, clearing on waitrequest=0 or on leaving the state.
REQ-030 With BUS_TIMEOUT_EN defined, when the count reaches TIMEOUT_CYCLES the next state SHALL be HALT, with bus_error=1 and active=0.
REQ-031 Without BUS_TIMEOUT_EN: no counter is built, bus_error is tied 0, and the block waits indefinitely on waitrequest.

Structure
REQ-032 Shared package cpu_pkg SHALL hold the state encodings and the opcode/function-code constants (load/store set, multdiv set), also used by the control decoder.
REQ-033 The timeout counter SHALL be a sub-module bus_timeout_counter, instantiated only under BUS_TIMEOUT_EN.

Verification
REQ-034 Reset then an ADDU (opcode 0, function_code 33) with waitrequest=0: state sequence 0,3,0; ir_load in cycle 1, pc_enable in cycle 2.
REQ-035 LW (opcode 35), waitrequest high for 3 cycles in MEM: state stays 2 for 4 cycles; pc_enable exactly once, on the cycle waitrequest falls.
REQ-036 DIV (function_code 26), md_busy high for 10 cycles after md_start: state 1 for 11 cycles; one md_start pulse; then pc_enable.
REQ-037 JR with next_pc_zero=1 at pc_enable: state goes to 4, active falls to 0; held for 20 cycles regardless of inputs.
REQ-038 With BUS_TIMEOUT_EN and TIMEOUT_CYCLES=8, waitrequest stuck high in FETCH: HALT after 8 stall cycles, bus_error=1; reset clears bus_error to 0.
REQ-039 Reset asserted in MEM with waitrequest=1: next state FETCH, pc_enable never asserted, active=0 for the reset cycle.
